// File: rtl/dma_read_engine.sv
// Strided 2-D read DMA: walks rows*row_beats beat addresses with at most MAX_OUTSTANDING reads in flight.
// Build macro DMA_ALIGN_CHECK_EN: a misaligned addr/stride completes at once with dma_err instead of being masked.
module dma_read_engine #(
   parameter int DATA_W          = 256,
   parameter int ADDR_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              dma_start,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [ADDR_W-1:0] dma_stride,
   input  logic [15:0]       dma_rows,
   input  logic [15:0]       dma_row_beats,
   output logic              dma_valid,
   output logic              dma_ready,
   output logic [DATA_W-1:0] dma_data,
   output logic              dma_done,
   output logic              dma_busy,
   output logic              dma_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                BEAT_BYTES = DATA_W / 8;
   localparam int                OUT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_W-1:0] BEAT_INC   = ADDR_W'(BEAT_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BEAT_BYTES - 1);
   localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OUT_W-1:0]  OUT_ONE    = OUT_W'(1);
   localparam logic [OUT_W-1:0]  OUT_ZERO   = OUT_W'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_row_addr;
   logic [ADDR_W-1:0] r_stride;
   logic [15:0]       r_rows;
   logic [15:0]       r_row_beats;
   logic [15:0]       r_row;
   logic [15:0]       r_beat;
   logic [31:0]       r_total;
   logic [31:0]       r_rcv;
   logic [31:0]       w_rcv_nxt;
   logic [OUT_W-1:0]  r_outstanding;
   logic [OUT_W-1:0]  w_out_nxt;
   logic              r_mem_req;
   logic              r_valid;
   logic              r_done;
   logic              r_busy;
   logic [DATA_W-1:0] r_data;
   logic              w_grant;
   logic              w_rsp_acc;
   logic              w_row_end;
   logic              w_last_req;
   logic              w_zero_len;
   logic              w_misaligned;
   logic [ADDR_W-1:0] w_addr_in;
   logic [ADDR_W-1:0] w_stride_in;

   assign w_grant    = r_mem_req & mem_gnt;
   assign w_rsp_acc  = mem_rvalid & (r_outstanding != OUT_ZERO);
   assign w_row_end  = (r_beat == (r_row_beats - 16'd1));
   assign w_last_req = w_row_end & (r_row == (r_rows - 16'd1));
   assign w_zero_len = (dma_rows == 16'd0) | (dma_row_beats == 16'd0);
   assign w_rcv_nxt  = r_rcv + {31'd0, w_rsp_acc};

`ifdef DMA_ALIGN_CHECK_EN
   logic r_err;

   assign w_misaligned = (((dma_addr | dma_stride) & ALIGN_MASK) != {ADDR_W{1'b0}});
   assign w_addr_in    = dma_addr;
   assign w_stride_in  = dma_stride;
   assign dma_err      = r_err;

   // Error pulse lines up with the immediate DONE of a misaligned start.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_err <= 1'b0;
      end else begin
         r_err <= (r_state == S_IDLE) && dma_start && w_misaligned;
      end
   end
`else
   assign w_misaligned = 1'b0;
   assign w_addr_in    = dma_addr & ~ALIGN_MASK;
   assign w_stride_in  = dma_stride & ~ALIGN_MASK;
   assign dma_err      = 1'b0;
`endif

   // Grant and accepted response in the same cycle cancel out.
   always_comb begin
      w_out_nxt = r_outstanding;
      if (w_grant && !w_rsp_acc) begin
         w_out_nxt = r_outstanding + OUT_ONE;
      end else if (!w_grant && w_rsp_acc) begin
         w_out_nxt = r_outstanding - OUT_ONE;
      end else begin
         w_out_nxt = r_outstanding;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (dma_start && (w_zero_len || w_misaligned)) begin
               w_state_nxt = S_DONE;
            end else if (dma_start) begin
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ: begin
            if (w_grant && w_last_req) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_DRAIN: begin
            if ((w_out_nxt == OUT_ZERO) && (w_rcv_nxt == r_total)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Transfer descriptor capture and address walk; address only advances on a grant.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_addr      <= {ADDR_W{1'b0}};
         r_row_addr  <= {ADDR_W{1'b0}};
         r_stride    <= {ADDR_W{1'b0}};
         r_rows      <= 16'd0;
         r_row_beats <= 16'd0;
         r_row       <= 16'd0;
         r_beat      <= 16'd0;
         r_total     <= 32'd0;
         r_rcv       <= 32'd0;
      end else if ((r_state == S_IDLE) && dma_start) begin
         r_addr      <= w_addr_in;
         r_row_addr  <= w_addr_in;
         r_stride    <= w_stride_in;
         r_rows      <= dma_rows;
         r_row_beats <= dma_row_beats;
         r_row       <= 16'd0;
         r_beat      <= 16'd0;
         r_total     <= 32'(dma_rows) * 32'(dma_row_beats);
         r_rcv       <= 32'd0;
      end else begin
         r_rcv <= w_rcv_nxt;
         if (w_grant) begin
            if (w_row_end) begin
               r_beat     <= 16'd0;
               r_row      <= r_row + 16'd1;
               r_row_addr <= r_row_addr + r_stride;
               r_addr     <= r_row_addr + r_stride;
            end else begin
               r_beat <= r_beat + 16'd1;
               r_addr <= r_addr + BEAT_INC;
            end
         end
      end
   end

   // Registered outputs, computed from next-state values so they line up with the state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_outstanding <= OUT_ZERO;
         r_mem_req     <= 1'b0;
         r_valid       <= 1'b0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
         r_data        <= {DATA_W{1'b0}};
      end else begin
         r_outstanding <= w_out_nxt;
         r_mem_req     <= (w_state_nxt == S_REQ) && (w_out_nxt < OUT_MAX);
         r_valid       <= w_rsp_acc;
         r_done        <= (w_state_nxt == S_DONE);
         r_busy        <= (w_state_nxt != S_IDLE);
         if (w_rsp_acc) begin
            r_data <= mem_rdata;
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_addr  = r_addr;
   assign dma_valid = r_valid;
   assign dma_ready = r_valid;
   assign dma_data  = r_data;
   assign dma_done  = r_done;
   assign dma_busy  = r_busy;

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine: a small memory model answers grants two cycles later with {8{addr}}.
module tb_dma_read_engine;
   localparam int DATA_W = 256;
   localparam int ADDR_W = 32;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic              clk           = 1'b0;
   logic              rstn          = 1'b0;
   logic              dma_start     = 1'b0;
   logic [31:0]       dma_addr      = 32'd0;
   logic [31:0]       dma_stride    = 32'd0;
   logic [15:0]       dma_rows      = 16'd0;
   logic [15:0]       dma_row_beats = 16'd0;
   logic              dma_valid, dma_ready, dma_done, dma_busy, dma_err, mem_req;
   logic [DATA_W-1:0] dma_data;
   logic [31:0]       mem_addr;
   logic              mem_gnt       = 1'b1;
   logic              mem_rvalid    = 1'b0;
   logic [DATA_W-1:0] mem_rdata     = {DATA_W{1'b0}};

   int n_vec = 0;
   int n_miscmp = 0;

   pend_t             pend[$];
   int                cyc        = 0;
   int                gnt_block  = 0;
   int                rsp_credit = -1;
   bit                stray_now  = 1'b0;

   logic [31:0]       grants[$];
   logic [DATA_W-1:0] beats[$];
   logic [31:0]       exp_q[$];
   int                req_cyc, stall_cnt, stall_bad, rdy_bad, done_cnt, done_idx, err_cnt;
   logic              done_val;
   logic [31:0]       stall_first;

   dma_read_engine #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .dma_start(dma_start),
      .dma_addr(dma_addr),
      .dma_stride(dma_stride),
      .dma_rows(dma_rows),
      .dma_row_beats(dma_row_beats),
      .dma_valid(dma_valid),
      .dma_ready(dma_ready),
      .dma_data(dma_data),
      .dma_done(dma_done),
      .dma_busy(dma_busy),
      .dma_err(dma_err),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] pat(input logic [31:0] a);
      return {8{a}};
   endfunction

   function automatic logic [31:0] g_at(input int i);
      return (i < grants.size()) ? grants[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [DATA_W-1:0] b_at(input int i);
      return (i < beats.size()) ? beats[i] : {DATA_W{1'bx}};
   endfunction

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model and event recorder, all on the falling edge away from DUT updates.
   always @(negedge clk) begin
      cyc = cyc + 1;
      mem_rvalid = 1'b0;
      if (stray_now) begin
         mem_rvalid = 1'b1;
         mem_rdata  = pat(32'hDEAD_BEEF);
         stray_now  = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc && rsp_credit != 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = pat(pend[0].addr);
         void'(pend.pop_front());
         if (rsp_credit > 0) rsp_credit = rsp_credit - 1;
      end
      mem_gnt = (gnt_block == 0);
      if (gnt_block > 0) gnt_block = gnt_block - 1;
      if (mem_req && mem_gnt) begin
         grants.push_back(mem_addr);
         pend.push_back('{mem_addr, cyc + 2});
      end else if (mem_req) begin
         if (stall_cnt == 0) stall_first = mem_addr;
         else if (mem_addr != stall_first) stall_bad++;
         stall_cnt++;
      end
      if (mem_req) req_cyc++;
      if (dma_valid) beats.push_back(dma_data);
      if (dma_ready != dma_valid) rdy_bad++;
      if (dma_done) begin
         done_cnt++;
         done_val = dma_valid;
         done_idx = beats.size();
      end
      if (dma_err) err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_rec();
      grants.delete();
      beats.delete();
      req_cyc = 0; stall_cnt = 0; stall_bad = 0; rdy_bad = 0;
      done_cnt = 0; done_idx = 0; err_cnt = 0; done_val = 1'b0;
      stall_first = 32'd0;
   endtask

   task automatic start_xfer(input logic [31:0] a, input logic [31:0] s,
                             input logic [15:0] r, input logic [15:0] b);
      dma_addr = a; dma_stride = s; dma_rows = r; dma_row_beats = b;
      dma_start = 1'b1;
      tick(1);
      dma_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && done_cnt == 0; k++) tick(1);
      tick(3);
   endtask

   task automatic verify_stream(input string tag);
      check_eq({tag, "_grants"}, grants.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), g_at(i), exp_q[i]);
         check_eq($sformatf("%s_data%0d", tag, i), b_at(i), pat(exp_q[i]));
      end
      check_eq({tag, "_beats"}, beats.size(), exp_q.size());
      check_eq({tag, "_done_cnt"}, done_cnt, 1);
      check_eq({tag, "_done_on_valid"}, done_val, 1'b1);
      check_eq({tag, "_done_idx"}, done_idx, exp_q.size());
      check_eq({tag, "_ready_eq_valid"}, rdy_bad, 0);
      check_eq({tag, "_busy_after"}, dma_busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      clear_rec();
      tick(3);
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_valid", dma_valid, 1'b0);
      check_eq("rst_ready", dma_ready, 1'b0);
      check_eq("rst_done", dma_done, 1'b0);
      check_eq("rst_busy", dma_busy, 1'b0);
      check_eq("rst_err", dma_err, 1'b0);
      check_eq("rst_data", dma_data, {DATA_W{1'b0}});
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      rstn = 1'b1;
      tick(2);

      // 2x2 strided transfer
      clear_rec();
      exp_q = '{32'h1000_0000, 32'h1000_0020, 32'h1000_0100, 32'h1000_0120};
      start_xfer(32'h1000_0000, 32'h0000_0100, 16'd2, 16'd2);
      check_eq("basic_busy_start", dma_busy, 1'b1);
      wait_done(100);
      verify_stream("basic");
      check_eq("basic_err", err_cnt, 0);

      // Outstanding limit with responses withheld
      clear_rec();
      rsp_credit = 0;
      start_xfer(32'h2000_0000, 32'h0000_0000, 16'd1, 16'd8);
      tick(12);
      check_eq("limit_grants", grants.size(), 4);
      check_eq("limit_req_low", mem_req, 1'b0);
      check_eq("limit_req_cycles", req_cyc, 4);
      rsp_credit = 1;
      tick(3);
      check_eq("limit_regrant", grants.size(), 5);
      check_eq("limit_regrant_addr", g_at(4), 32'h2000_0080);
      check_eq("limit_req_low2", mem_req, 1'b0);
      rsp_credit = -1;
      wait_done(100);
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back(32'h2000_0000 + 32'(k * 32));
      verify_stream("limit");

      // Grant stall: request and address must hold
      clear_rec();
      gnt_block = 4;
      start_xfer(32'h3000_0000, 32'h0000_0000, 16'd1, 16'd3);
      wait_done(100);
      check_eq("stall_cycles", stall_cnt, 3);
      check_eq("stall_addr_first", stall_first, 32'h3000_0000);
      check_eq("stall_addr_moved", stall_bad, 0);
      exp_q = '{32'h3000_0000, 32'h3000_0020, 32'h3000_0040};
      verify_stream("stall");

      // Zero-length transfers
      clear_rec();
      start_xfer(32'h5000_0000, 32'h0000_0100, 16'd0, 16'd4);
      check_eq("zrows_done", dma_done, 1'b1);
      check_eq("zrows_busy", dma_busy, 1'b1);
      check_eq("zrows_err", dma_err, 1'b0);
      tick(1);
      check_eq("zrows_done_off", dma_done, 1'b0);
      check_eq("zrows_busy_off", dma_busy, 1'b0);
      tick(3);
      check_eq("zrows_req", req_cyc, 0);
      check_eq("zrows_done_cnt", done_cnt, 1);
      clear_rec();
      start_xfer(32'h5000_0000, 32'h0000_0100, 16'd3, 16'd0);
      check_eq("zbeats_done", dma_done, 1'b1);
      tick(3);
      check_eq("zbeats_req", req_cyc, 0);
      check_eq("zbeats_valid", beats.size(), 0);

      // Reset mid-transfer, stray response, then rerun
      clear_rec();
      start_xfer(32'h4000_0000, 32'h0000_0040, 16'd2, 16'd2);
      for (int k = 0; k < 50 && beats.size() < 2; k++) tick(1);
      check_eq("rst_mid_beats", beats.size(), 2);
      rstn = 1'b0;
      tick(1);
      clear_rec();
      rstn = 1'b1;
      stray_now = 1'b1;
      tick(10);
      check_eq("rst_mid_valid", beats.size(), 0);
      check_eq("rst_mid_done", done_cnt, 0);
      check_eq("rst_mid_req", req_cyc, 0);
      check_eq("rst_mid_busy", dma_busy, 1'b0);
      clear_rec();
      exp_q = '{32'h4000_0000, 32'h4000_0020, 32'h4000_0040, 32'h4000_0060};
      start_xfer(32'h4000_0000, 32'h0000_0040, 16'd2, 16'd2);
      wait_done(100);
      verify_stream("rst_rerun");

      // Misaligned base address
      clear_rec();
`ifdef DMA_ALIGN_CHECK_EN
      start_xfer(32'h1000_0010, 32'h0000_0100, 16'd1, 16'd1);
      check_eq("align_err", dma_err, 1'b1);
      check_eq("align_done", dma_done, 1'b1);
      tick(3);
      check_eq("align_req", req_cyc, 0);
      check_eq("align_err_cnt", err_cnt, 1);
`else
      exp_q = '{32'h1000_0000};
      start_xfer(32'h1000_0010, 32'h0000_0100, 16'd1, 16'd1);
      wait_done(100);
      verify_stream("align_mask");
      check_eq("align_err_cnt", err_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/dma_read_engine.md
DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 Parameters SHALL be: DATA_W, default 256, beat width in bits; ADDR_W, default 32, byte address width; MAX_OUTSTANDING, default 4, maximum granted-but-unreturned reads.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- dma_start  in  1  single-cycle transfer start
- dma_addr  in  ADDR_W  first-row byte base
- dma_stride  in  ADDR_W  row-to-row byte offset
- dma_rows  in  16  row count
- dma_row_beats  in  16  beats per row
- dma_valid  out  1  beat on dma_data
- dma_ready  out  1  beat strobe toward the control register
- dma_data  out  DATA_W  beat payload
- dma_done  out  1  transfer-complete pulse
- dma_busy  out  1  transfer in progress
- dma_err  out  1  alignment error pulse
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  request byte address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  in-order read response
- mem_rdata  in  DATA_W  response data

Function
REQ-004 States SHALL be IDLE, REQ, DRAIN, DONE.
REQ-005 IDLE plus dma_start SHALL latch all dma_* inputs, clear the row and beat counters, and enter REQ; dma_start outside IDLE SHALL be ignored.
REQ-006 If dma_rows==0 or dma_row_beats==0, IDLE SHALL go directly to DONE with no mem_req.
REQ-007 Request address SHALL be base + row*stride + beat*(DATA_W/8), computed modulo 2^ADDR_W with wrap-around.
REQ-008 Request order SHALL be beat-major within a row, then row-major.
REQ-009 mem_req SHALL be high in REQ while outstanding < MAX_OUTSTANDING.
REQ-010 A request SHALL count as issued only on a cycle with mem_req && mem_gnt.
REQ-011 mem_addr SHALL hold stable while mem_req is high and mem_gnt is low.
REQ-012 The outstanding counter SHALL increment on each grant and decrement on each mem_rvalid; a simultaneous grant and rvalid SHALL leave it unchanged.
REQ-013 After the last grant, REQ SHALL go to DRAIN. DRAIN SHALL go to DONE when outstanding reaches 0 and the total received beat count equals rows*row_beats.
REQ-014 Each mem_rvalid with outstanding>0 SHALL produce dma_valid=dma_ready=1 and dma_data=mem_rdata on the next cycle, as a registered 1-cycle latency with no backpressure.
REQ-015 mem_rvalid arriving with outstanding==0 SHALL be dropped.
REQ-016 dma_done SHALL pulse for exactly one cycle coincident with the last beat's dma_valid.
REQ-017 For zero-length transfers, dma_done SHALL pulse in the cycle after dma_start.
REQ-018 DONE SHALL return to IDLE in one cycle.
REQ-019 dma_busy SHALL be high in every state except IDLE.

Reset
REQ-020 rstn low at a clock edge SHALL force IDLE and clear all counters.
REQ-021 On reset, mem_req, dma_valid, dma_ready, dma_done, dma_busy and dma_err SHALL be 0, and dma_data and mem_addr SHALL be 0.
REQ-022 Reset mid-transfer SHALL abandon the transfer without asserting dma_done. Late responses after reset SHALL be dropped per REQ-015.

Configuration
REQ-023 Macro DMA_ALIGN_CHECK_EN defined: dma_start with a nonzero dma_addr or dma_stride low log2(DATA_W/8) bits SHALL issue no requests. The engine SHALL enter DONE and pulse dma_err together with dma_done one cycle after start.
REQ-024 Macro DMA_ALIGN_CHECK_EN undefined: those low bits SHALL be forced to 0 internally, and dma_err SHALL be tied to 0.

Verification
REQ-025 Stimulus: addr=0x1000_0000, stride=0x100, rows=2, row_beats=2, mem_gnt always 1, rvalid 2 cycles after grant. Required response: mem_addr sequence 0x1000_0000, 0x1000_0020, 0x1000_0100, 0x1000_0120; 4 dma_valid beats; dma_done on the 4th.
REQ-026 Stimulus: rows=1, row_beats=8, responses withheld. Required response: exactly 4 grants, then mem_req low; releasing one rvalid re-raises mem_req.
REQ-027 Stimulus: mem_gnt low for 3 cycles. Required response: mem_req and mem_addr held constant; no beat skipped or duplicated.
REQ-028 Stimulus: rows=0. Required response: no mem_req; dma_done pulse at start+1; dma_busy high for one cycle.
REQ-029 Stimulus: rstn pulsed low after 2 of 4 beats, then stray mem_rvalid. Required response: no dma_valid and no dma_done; a new transfer then runs correctly.
REQ-030 Stimulus: with DMA_ALIGN_CHECK_EN defined, addr=0x1000_0010. Required response: dma_err=dma_done=1 at start+1 with no mem_req; without the macro, the first mem_addr is 0x1000_0000.
